// File: rtl/mux_8to1_if.sv
// Lane-select bus for mux_8to1: capture request (en, i, s) towards the mux, registered lane back.
// When MUX_8TO1_PARITY_EN is defined the bus also carries the registered lane parity o_par.
interface mux_8to1_if #(
  parameter int WIDTH = 1
);
  logic                 en;
  logic [8*WIDTH-1:0]   i;
  logic [2:0]           s;
  logic [WIDTH-1:0]     o;
  logic                 o_vld;
`ifdef MUX_8TO1_PARITY_EN
  logic                 o_par;

  modport master (
    output en, i, s,
    input  o, o_vld, o_par
  );

  modport slave (
    input  en, i, s,
    output o, o_vld, o_par
  );
`else
  modport master (
    output en, i, s,
    input  o, o_vld
  );

  modport slave (
    input  en, i, s,
    output o, o_vld
  );
`endif
endinterface

// File: rtl/mux_8to1.sv
// Registered 8:1 lane multiplexer: o = lane[s] one clock after an enabled capture.
// Optional MUX_8TO1_PARITY_EN adds a registered XOR-reduction of the selected lane on o_par.
module mux_8to1 #(
  parameter int WIDTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  mux_8to1_if.slave bus
);

`ifdef MUX_8TO1_PARITY_EN
  function automatic logic lane_parity(input logic [WIDTH-1:0] lane);
    return ^lane;
  endfunction
`endif

  logic [WIDTH-1:0] sel_p0;
  logic [WIDTH-1:0] o_p1;
  logic             vld_p1;
`ifdef MUX_8TO1_PARITY_EN
  logic             par_p1;
`endif

  // Stage p0: combinational lane pick from the current bus inputs.
  always_comb begin
    sel_p0 = '0;
    for (int k = 0; k < 8; k++) begin
      if (bus.s == 3'(k)) begin
        sel_p0 = bus.i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage p1: output register; the data holds when en is low so o stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_p1   <= '0;
      vld_p1 <= 1'b0;
`ifdef MUX_8TO1_PARITY_EN
      par_p1 <= 1'b0;
`endif
    end else begin
      vld_p1 <= bus.en;
      if (bus.en) begin
        o_p1   <= sel_p0;
`ifdef MUX_8TO1_PARITY_EN
        par_p1 <= lane_parity(sel_p0);
`endif
      end
    end
  end

  assign bus.o     = o_p1;
  assign bus.o_vld = vld_p1;
`ifdef MUX_8TO1_PARITY_EN
  assign bus.o_par = par_p1;
`endif

endmodule

// File: tb/tb_mux_8to1.sv
// Directed table-driven bench for mux_8to1: a WIDTH=1 instance and a WIDTH=8 instance.
// Parity expectations are compared only when MUX_8TO1_PARITY_EN is defined.
module tb_mux_8to1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_8to1_if #(.WIDTH(1)) bus1 ();
  mux_8to1_if #(.WIDTH(8)) bus8 ();

  mux_8to1 #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_8to1 #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [7:0] i;
    logic [2:0] s;
    logic       exp_o;
    logic       exp_vld;
  } vec1_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [2:0] s;
    logic [7:0] exp_o;
    logic       exp_vld;
    logic       exp_par;
  } vec8_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec1_t t1[$];
  vec8_t t8[$];
  logic [63:0] lanes8;

  initial begin
    bus1.en = 1'b0; bus1.i = '0; bus1.s = '0;
    bus8.en = 1'b0; bus8.i = '0; bus8.s = '0;
    for (int k = 0; k < 8; k++) lanes8[k*8 +: 8] = 8'h10 + 8'(k);

    // WIDTH=1 vectors: inputs applied before the edge, expected outputs after it.
    t1.push_back('{"rst_a",    1, 1, 8'hFF, 3'd0, 0, 0});
    t1.push_back('{"rst_b",    1, 1, 8'hFF, 3'd7, 0, 0});
    t1.push_back('{"post_rst", 0, 0, 8'hFF, 3'd7, 0, 0});
    t1.push_back('{"sweep_s0", 0, 1, 8'b10101100, 3'd0, 0, 1});
    t1.push_back('{"sweep_s1", 0, 1, 8'b10101100, 3'd1, 0, 1});
    t1.push_back('{"sweep_s2", 0, 1, 8'b10101100, 3'd2, 1, 1});
    t1.push_back('{"sweep_s3", 0, 1, 8'b10101100, 3'd3, 1, 1});
    t1.push_back('{"sweep_s4", 0, 1, 8'b10101100, 3'd4, 0, 1});
    t1.push_back('{"sweep_s5", 0, 1, 8'b10101100, 3'd5, 1, 1});
    t1.push_back('{"sweep_s6", 0, 1, 8'b10101100, 3'd6, 0, 1});
    t1.push_back('{"sweep_s7", 0, 1, 8'b10101100, 3'd7, 1, 1});
    t1.push_back('{"chg_s0",   0, 1, 8'b01010011, 3'd0, 1, 1});
    t1.push_back('{"chg_s3",   0, 1, 8'b01010011, 3'd3, 0, 1});
    t1.push_back('{"chg_s7",   0, 1, 8'b01010011, 3'd7, 0, 1});
    t1.push_back('{"hold_cap", 0, 1, 8'b10101100, 3'd2, 1, 1});
    t1.push_back('{"hold_1",   0, 0, 8'h00, 3'd0, 1, 0});
    t1.push_back('{"hold_2",   0, 0, 8'h00, 3'd0, 1, 0});
    t1.push_back('{"hold_3",   0, 0, 8'h00, 3'd0, 1, 0});

    // WIDTH=8 vectors with lane k = 8'h10+k; parity is the XOR of the lane bits.
    t8.push_back('{"w8_rst_pri", 1, 1, 3'd5, 8'h00, 0, 0});
    t8.push_back('{"w8_s5",      0, 1, 3'd5, 8'h15, 1, 1});
    t8.push_back('{"w8_s3",      0, 1, 3'd3, 8'h13, 1, 1});
    t8.push_back('{"w8_s1",      0, 1, 3'd1, 8'h11, 1, 0});
    t8.push_back('{"w8_s7",      0, 1, 3'd7, 8'h17, 1, 0});
    t8.push_back('{"w8_s0",      0, 1, 3'd0, 8'h10, 1, 1});
    t8.push_back('{"w8_hold",    0, 0, 3'd6, 8'h10, 0, 1});
    t8.push_back('{"w8_s6",      0, 1, 3'd6, 8'h16, 1, 1});
    t8.push_back('{"w8_midrst",  1, 1, 3'd2, 8'h00, 0, 0});
    t8.push_back('{"w8_s2",      0, 1, 3'd2, 8'h12, 1, 0});

    foreach (t1[n]) begin
      rst     = t1[n].rst;
      bus1.en = t1[n].en;
      bus1.i  = t1[n].i;
      bus1.s  = t1[n].s;
      step();
      check({t1[n].name, "_o"},   32'(bus1.o),     32'(t1[n].exp_o));
      check({t1[n].name, "_vld"}, 32'(bus1.o_vld), 32'(t1[n].exp_vld));
    end
    bus1.en = 1'b0;

    bus8.i = lanes8;
    foreach (t8[n]) begin
      rst     = t8[n].rst;
      bus8.en = t8[n].en;
      bus8.s  = t8[n].s;
      step();
      check({t8[n].name, "_o"},   32'(bus8.o),     32'(t8[n].exp_o));
      check({t8[n].name, "_vld"}, 32'(bus8.o_vld), 32'(t8[n].exp_vld));
`ifdef MUX_8TO1_PARITY_EN
      check({t8[n].name, "_par"}, 32'(bus8.o_par), 32'(t8[n].exp_par));
`endif
    end

    // Simultaneous i and s change: both must be sampled at the same edge.
    rst = 1'b0;
    bus8.en = 1'b1;
    bus8.i  = {8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus8.s  = 3'd4;
    step();
    check("w8_simul_o", 32'(bus8.o), 32'h0000_00A4);
    bus8.i  = {8'h5F, 8'h5E, 8'h5D, 8'h5C, 8'h5B, 8'h5A, 8'h59, 8'h58};
    bus8.s  = 3'd6;
    step();
    check("w8_b2b_o", 32'(bus8.o), 32'h0000_005E);
    check("w8_b2b_vld", 32'(bus8.o_vld), 32'd1);
    bus8.en = 1'b0;
    step();
    check("w8_idle_vld", 32'(bus8.o_vld), 32'd0);
    check("w8_idle_o", 32'(bus8.o), 32'h0000_005E);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
